// File: rtl/icap_arbiter.sv
// Two-master ICAP arbiter: PRC has priority over SEM, SEM ownership is revoked
// through the cap_rel handshake, and an idle gap separates consecutive owners.
module icap_arbiter #(
    parameter int unsigned GAP_CYCLES  = 4,
    parameter int unsigned REL_TIMEOUT = 1023
) (
    input  logic        icap_clk,
    input  logic        icap_resetn,
    input  logic        sem_cap_req,
    output logic        sem_cap_gnt,
    output logic        sem_cap_rel,
    input  logic        sem_icap_csib,
    input  logic        sem_icap_rdwrb,
    input  logic [31:0] sem_icap_i,
    input  logic        prc_req,
    output logic        prc_gnt,
    input  logic        prc_icap_csib,
    input  logic        prc_icap_rdwrb,
    input  logic [31:0] prc_icap_i,
    output logic        icap_csib,
    output logic        icap_rdwrb,
    output logic [31:0] icap_i,
    output logic [1:0]  owner,
    output logic        rel_timeout
);

    localparam int unsigned REL_W = (REL_TIMEOUT < 2) ? 1 : $clog2(REL_TIMEOUT + 1);
    localparam logic [3:0]       GAP_LOAD  = 4'(GAP_CYCLES - 1);
    localparam logic [REL_W-1:0] REL_LIMIT = REL_W'(REL_TIMEOUT);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEM_OWN,
        ST_SEM_REL,
        ST_PRC_OWN,
        ST_GAP
    } state_t;

    state_t           state;
    logic [3:0]       gap_cnt;
    logic [REL_W-1:0] rel_cnt;

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values of its neighbours.
    always_ff @(posedge icap_clk) begin
        if (!icap_resetn) begin
            state       <= ST_IDLE;
            gap_cnt     <= '0;
            rel_cnt     <= '0;
            rel_timeout <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (prc_req)
                        state <= ST_PRC_OWN;
                    else if (sem_cap_req)
                        state <= ST_SEM_OWN;
                end
                ST_SEM_OWN: begin
                    if (!sem_cap_req) begin
                        state   <= ST_GAP;
                        gap_cnt <= GAP_LOAD;
                    end else if (prc_req) begin
                        state   <= ST_SEM_REL;
                        rel_cnt <= '0;
                    end
                end
                ST_SEM_REL: begin
                    // SEM letting go wins over PRC withdrawing in the same cycle.
                    if (!sem_cap_req) begin
                        state   <= ST_GAP;
                        gap_cnt <= GAP_LOAD;
                    end else if (!prc_req) begin
                        state <= ST_SEM_OWN;
                    end else if (rel_cnt == REL_LIMIT) begin
                        rel_timeout <= 1'b1;
                    end else begin
                        rel_cnt <= rel_cnt + 1'b1;
                    end
                end
                ST_PRC_OWN: begin
                    if (!prc_req) begin
                        state   <= ST_GAP;
                        gap_cnt <= GAP_LOAD;
                    end
                end
                ST_GAP: begin
                    if (gap_cnt == 4'd0)
                        state <= ST_IDLE;
                    else
                        gap_cnt <= gap_cnt - 1'b1;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // NOTE: every output gets a default before the case so no latch is inferred.
    always_comb begin
        sem_cap_gnt = 1'b0;
        sem_cap_rel = 1'b0;
        prc_gnt     = 1'b0;
        icap_csib   = 1'b1;
        icap_rdwrb  = 1'b1;
        icap_i      = '0;
        owner       = 2'b00;
        case (state)
            ST_SEM_OWN, ST_SEM_REL: begin
                sem_cap_gnt = 1'b1;
                sem_cap_rel = (state == ST_SEM_REL);
                icap_csib   = sem_icap_csib;
                icap_rdwrb  = sem_icap_rdwrb;
                icap_i      = sem_icap_i;
                owner       = 2'b01;
            end
            ST_PRC_OWN: begin
                prc_gnt    = 1'b1;
                icap_csib  = prc_icap_csib;
                icap_rdwrb = prc_icap_rdwrb;
                icap_i     = prc_icap_i;
                owner      = 2'b10;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_icap_arbiter.sv
// Scoreboard bench for icap_arbiter: a behavioural ownership model predicts
// every cycle's outputs; a separate monitor compares them against the DUT.
module tb_icap_arbiter;

    localparam int GAP = 4;
    localparam int TO  = 1023;

    logic        icap_clk = 1'b0;
    logic        icap_resetn = 1'b0;
    logic        sem_cap_req = 1'b0, sem_icap_csib = 1'b1, sem_icap_rdwrb = 1'b1;
    logic [31:0] sem_icap_i = '0;
    logic        prc_req = 1'b0, prc_icap_csib = 1'b1, prc_icap_rdwrb = 1'b1;
    logic [31:0] prc_icap_i = '0;
    logic        sem_cap_gnt, sem_cap_rel, prc_gnt, icap_csib, icap_rdwrb, rel_timeout;
    logic [31:0] icap_i;
    logic [1:0]  owner;

    icap_arbiter #(.GAP_CYCLES(GAP), .REL_TIMEOUT(TO)) dut (
        .icap_clk(icap_clk), .icap_resetn(icap_resetn),
        .sem_cap_req(sem_cap_req), .sem_cap_gnt(sem_cap_gnt), .sem_cap_rel(sem_cap_rel),
        .sem_icap_csib(sem_icap_csib), .sem_icap_rdwrb(sem_icap_rdwrb), .sem_icap_i(sem_icap_i),
        .prc_req(prc_req), .prc_gnt(prc_gnt),
        .prc_icap_csib(prc_icap_csib), .prc_icap_rdwrb(prc_icap_rdwrb), .prc_icap_i(prc_icap_i),
        .icap_csib(icap_csib), .icap_rdwrb(icap_rdwrb), .icap_i(icap_i),
        .owner(owner), .rel_timeout(rel_timeout)
    );

    always #5 icap_clk = ~icap_clk;

    typedef struct packed {
        logic        sem_gnt;
        logic        sem_rel;
        logic        prc_gnt;
        logic        csib;
        logic        rdwrb;
        logic [31:0] data;
        logic [1:0]  own;
        logic        to;
    } obs_t;

    obs_t q[$];
    int   tests = 0;
    int   fails = 0;
    logic fixed_data = 1'b0;

    // Reference model: who holds the port, whether a release is pending,
    // how many idle cycles remain, and how long SEM has ignored the demand.
    int   m_holder  = 0;   // 0 nobody, 1 SEM, 2 PRC
    bit   m_release = 0;
    int   m_gap     = 0;
    int   m_wait    = 0;
    bit   m_to      = 0;

    task automatic model_step();
        if (!icap_resetn) begin
            m_holder = 0; m_release = 0; m_gap = 0; m_wait = 0; m_to = 0;
        end else if (m_gap > 0) begin
            m_gap--;
        end else if (m_holder == 0) begin
            if (prc_req) m_holder = 2;
            else if (sem_cap_req) m_holder = 1;
        end else if (m_holder == 2) begin
            if (!prc_req) begin m_holder = 0; m_gap = GAP; end
        end else if (!m_release) begin
            if (!sem_cap_req) begin m_holder = 0; m_gap = GAP; end
            else if (prc_req) begin m_release = 1; m_wait = 0; end
        end else begin
            if (!sem_cap_req) begin m_holder = 0; m_release = 0; m_gap = GAP; end
            else if (!prc_req) m_release = 0;
            else if (m_wait >= TO) m_to = 1;
            else m_wait++;
        end
    endtask

    function automatic obs_t model_out();
        obs_t e;
        e.sem_gnt = (m_holder == 1);
        e.sem_rel = (m_holder == 1) && m_release;
        e.prc_gnt = (m_holder == 2);
        e.to      = m_to;
        case (m_holder)
            1:       begin e.csib = sem_icap_csib; e.rdwrb = sem_icap_rdwrb; e.data = sem_icap_i; e.own = 2'b01; end
            2:       begin e.csib = prc_icap_csib; e.rdwrb = prc_icap_rdwrb; e.data = prc_icap_i; e.own = 2'b10; end
            default: begin e.csib = 1'b1; e.rdwrb = 1'b1; e.data = 32'h0; e.own = 2'b00; end
        endcase
        return e;
    endfunction

    task automatic cyc(input logic rstn, input logic sem, input logic prc, input int n);
        for (int c = 0; c < n; c++) begin
            @(negedge icap_clk);
            icap_resetn    = rstn;
            sem_cap_req    = sem;
            prc_req        = prc;
            sem_icap_csib  = 1'($urandom_range(0, 1));
            sem_icap_rdwrb = 1'($urandom_range(0, 1));
            sem_icap_i     = fixed_data ? 32'hAA995566 : $urandom;
            prc_icap_csib  = 1'($urandom_range(0, 1));
            prc_icap_rdwrb = 1'($urandom_range(0, 1));
            prc_icap_i     = $urandom;
            @(posedge icap_clk);
            model_step();
            q.push_back(model_out());
        end
    endtask

    // Monitor: one observation per cycle, sampled just after the edge.
    initial begin
        obs_t e, a;
        forever begin
            @(posedge icap_clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                a = '{sem_cap_gnt, sem_cap_rel, prc_gnt, icap_csib, icap_rdwrb, icap_i, owner, rel_timeout};
                tests++;
                if (a !== e) begin
                    fails++;
                    $display("FAIL outputs t=%0t: got gnt=%b rel=%b pgnt=%b csib=%b rdwrb=%b i=%h own=%b to=%b, want gnt=%b rel=%b pgnt=%b csib=%b rdwrb=%b i=%h own=%b to=%b",
                             $time, a.sem_gnt, a.sem_rel, a.prc_gnt, a.csib, a.rdwrb, a.data, a.own, a.to,
                             e.sem_gnt, e.sem_rel, e.prc_gnt, e.csib, e.rdwrb, e.data, e.own, e.to);
                end
                tests++;
                if (sem_cap_gnt === 1'b1 && prc_gnt === 1'b1) begin
                    fails++;
                    $display("FAIL exclusive_grants t=%0t: got both grants high, want at most one", $time);
                end
            end
        end
    end

    initial begin
        logic s, p, r;
        // Reset, then SEM request with a known data word.
        cyc(1'b0, 1'b0, 1'b0, 3);
        cyc(1'b1, 1'b0, 1'b0, 2);
        fixed_data = 1'b1;
        cyc(1'b1, 1'b1, 1'b0, 4);
        // PRC demands; SEM holds 10 cycles, releases, PRC gets it after the gap.
        cyc(1'b1, 1'b1, 1'b1, 10);
        fixed_data = 1'b0;
        cyc(1'b1, 1'b0, 1'b1, 10);
        cyc(1'b1, 1'b0, 1'b0, 8);
        // Simultaneous requests from IDLE, then PRC drops and SEM follows.
        cyc(1'b1, 1'b1, 1'b1, 4);
        cyc(1'b1, 1'b1, 1'b0, 10);
        // Short PRC pulse during SEM ownership: no gap, no PRC grant.
        cyc(1'b1, 1'b1, 1'b1, 3);
        cyc(1'b1, 1'b1, 1'b0, 5);
        cyc(1'b1, 1'b0, 1'b0, 8);

        // Randomized traffic with occasional resets.
        s = 1'b0; p = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 7) == 0) s = ~s;
            if ($urandom_range(0, 9) == 0) p = ~p;
            r = ($urandom_range(0, 399) != 0);
            cyc(r, s, p, 1);
        end

        // SEM ignores the release demand long enough to hit the timeout.
        cyc(1'b0, 1'b0, 1'b0, 2);
        cyc(1'b1, 1'b1, 1'b0, 3);
        cyc(1'b1, 1'b1, 1'b1, 1100);
        cyc(1'b1, 1'b0, 1'b1, 12);
        cyc(1'b1, 1'b0, 1'b0, 8);
        cyc(1'b1, 1'b1, 1'b0, 4);

        // Reset while PRC owns; a held PRC request is re-granted right after.
        cyc(1'b1, 1'b0, 1'b0, 8);
        cyc(1'b1, 1'b0, 1'b1, 4);
        cyc(1'b0, 1'b0, 1'b1, 1);
        cyc(1'b1, 1'b0, 1'b1, 4);

        repeat (3) @(negedge icap_clk);
        tests++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL drain: got %0d unchecked entries, want 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
